dct_row_loader: RTL and testbench

//  Upstream stage of the 1-D DCT butterfly. Collects a raster stream of 8-bit pixels,
//  one per cycle, into 8-sample rows. Presents each row as 8 parallel samples x0..x7.
//  The butterfly consumes x0/x2/x4/x6 as its a/c/e/g inputs. Ping-pong double buffering

---
 rtl/jpeg_dct_pkg.sv | 17 +
 rtl/dct_row_bank.sv | 51 +++++
 rtl/dct_row_loader.sv | 125 ++++++++++++
 tb/tb_dct_row_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_dct_pkg.sv
// Shared constants and types for the JPEG DCT front end.
// Optional feature macro used by dct_row_loader: DCT_LEVEL_SHIFT_EN.
package jpeg_dct_pkg;

    localparam int DCT_N = 8;
    localparam int PIX_W = 8;
    localparam logic [PIX_W-1:0] LVL_OFFSET = 8'h80;

    // One DCT row of raw pixel-width samples, index 0 = first pixel of the row.
    typedef logic [DCT_N-1:0][PIX_W-1:0] row_t;

    // JPEG level shift: flipping the MSB maps 0..255 onto -128..127 in two's complement.
    function automatic logic [PIX_W-1:0] level_shift(input logic [PIX_W-1:0] p);
        return p ^ LVL_OFFSET;
    endfunction

endpackage

// File: rtl/dct_row_bank.sv
// One row buffer of the ping-pong pair: DEPTH sample registers plus a "full" flag.
// The owner never sets and clears the flag in the same cycle: a bank is only
// written while empty and only drained while full.
module dct_row_bank
    import jpeg_dct_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int DEPTH  = DCT_N,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [IDX_W-1:0]             wr_idx_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         set_full_i,
    input  logic                         clr_full_i,
    output logic [DEPTH-1:0][DATA_W-1:0] row_o,
    output logic                         full_o
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic                         full_q, full_d;

    // Next-state for the sample slots and the full flag.
    always_comb begin
        mem_d  = mem_q;
        full_d = full_q;
        if (wr_en_i)
            mem_d[wr_idx_i] = wr_data_i;
        if (set_full_i)
            full_d = 1'b1;
        else if (clr_full_i)
            full_d = 1'b0;
    end

    // Bank storage; reset clears samples so an idle output reads as zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            full_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            full_q <= full_d;
        end
    end

    assign row_o  = mem_q;
    assign full_o = full_q;

endmodule

// File: rtl/dct_row_loader.sv
// Collects a raster pixel stream into 8-sample rows for the 1-D DCT butterfly,
// double-buffered so row N+1 fills while row N waits downstream.
// Optional feature: define DCT_LEVEL_SHIFT_EN to store pix-128 (MSB flipped)
// instead of the raw unsigned pixel; timing and handshakes are unchanged.
module dct_row_loader
    import jpeg_dct_pkg::*;
#(
    parameter int DATA_W   = PIX_W,
    parameter int ROW_LEN  = DCT_N,
    parameter int BLK_ROWS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] x4,
    output logic [DATA_W-1:0] x5,
    output logic [DATA_W-1:0] x6,
    output logic [DATA_W-1:0] x7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_row,
    output logic              out_last
);

    localparam int IDX_W = $clog2(ROW_LEN);
    // Generic MSB flip; equals LVL_OFFSET at the default 8-bit width.
    localparam logic [DATA_W-1:0] SHIFT = {1'b1, {(DATA_W-1){1'b0}}};

    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q,  wr_idx_d;
    logic [2:0]       row_cnt_q, row_cnt_d;

    logic [1:0]                             full;
    logic [1:0][ROW_LEN-1:0][DATA_W-1:0]    rows;
    logic [ROW_LEN-1:0][DATA_W-1:0]         rd_row;
    logic [DATA_W-1:0]                      wr_data;
    logic                                   pix_acc, row_done, row_acc;

    assign pix_ready = ~full[wr_bank_q];
    assign out_valid = full[rd_bank_q];
    assign pix_acc   = pix_valid & pix_ready;
    assign row_done  = pix_acc & (wr_idx_q == IDX_W'(ROW_LEN - 1));
    assign row_acc   = out_valid & out_ready;

`ifdef DCT_LEVEL_SHIFT_EN
    assign wr_data = pix_in ^ SHIFT;
`else
    assign wr_data = pix_in;
`endif

    // Ping-pong banks: completion of one and drain of the other may coincide
    // because they always target different flags.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_row_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (ROW_LEN)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (pix_acc  & (wr_bank_q == 1'(b))),
            .wr_idx_i   (wr_idx_q),
            .wr_data_i  (wr_data),
            .set_full_i (row_done & (wr_bank_q == 1'(b))),
            .clr_full_i (row_acc  & (rd_bank_q == 1'(b))),
            .row_o      (rows[b]),
            .full_o     (full[b])
        );
    end

    // Next-state for write/read pointers, fill index and block row counter.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        row_cnt_d = row_cnt_q;
        if (pix_acc) begin
            if (row_done) begin
                wr_idx_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_idx_d  = wr_idx_q + 1'b1;
            end
        end
        if (row_acc) begin
            rd_bank_d = ~rd_bank_q;
            row_cnt_d = (row_cnt_q == 3'(BLK_ROWS - 1)) ? 3'd0 : row_cnt_q + 3'd1;
        end
    end

    // Pointer/counter registers; reset drops any partial or waiting rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            row_cnt_q <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Outputs come straight from bank registers, so they hold while stalled.
    assign rd_row   = rows[rd_bank_q];
    assign x0       = rd_row[0];
    assign x1       = rd_row[1];
    assign x2       = rd_row[2];
    assign x3       = rd_row[3];
    assign x4       = rd_row[4];
    assign x5       = rd_row[5];
    assign x6       = rd_row[6];
    assign x7       = rd_row[7];
    assign out_row  = row_cnt_q;
    assign out_last = (row_cnt_q == 3'(BLK_ROWS - 1));

endmodule

// File: tb/tb_dct_row_loader.sv
// Directed bench for dct_row_loader with a queue-based reference model.
module tb_dct_row_loader;
    import jpeg_dct_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_row;
    logic       out_last;

    int checks = 0;
    int fails  = 0;

    dct_row_loader dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .x5        (x5),
        .x6        (x6),
        .x7        (x7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xf(input logic [7:0] v);
`ifdef DCT_LEVEL_SHIFT_EN
        return v ^ 8'h80;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model: rows waiting downstream + partial row ----
    row_t pend[$];
    row_t part;
    int   pcnt     = 0;
    int   rows_out = 0;
    bit   armed    = 0;
    bit   m_rdy, m_vld;

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            pcnt     = 0;
            rows_out = 0;
            armed    = 1;
        end else if (armed) begin
            m_rdy = (pend.size() < 2);
            m_vld = (pend.size() > 0);
            if (m_vld && out_ready) begin
                void'(pend.pop_front());
                rows_out++;
            end
            if (pix_valid && m_rdy) begin
                part[pcnt] = xf(pix_in);
                pcnt++;
                if (pcnt == 8) begin
                    pend.push_back(part);
                    pcnt = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------------
    logic [7:0] xv [8];
    assign xv[0] = x0; assign xv[1] = x1; assign xv[2] = x2; assign xv[3] = x3;
    assign xv[4] = x4; assign xv[5] = x5; assign xv[6] = x6; assign xv[7] = x7;

    always @(posedge clk) begin
        #2;
        if (armed) begin
            chk("m_pix_ready", 32'(pix_ready), 32'(pend.size() < 2));
            chk("m_out_valid", 32'(out_valid), 32'(pend.size() > 0));
            chk("m_out_row",   32'(out_row),   32'(rows_out % 8));
            chk("m_out_last",  32'(out_last),  32'((rows_out % 8) == 7));
            if (pend.size() > 0)
                for (int k = 0; k < 8; k++)
                    chk("m_x", 32'(xv[k]), 32'(pend[0][k]));
        end
    end

    // ---------------- stimulus helpers ------------------------------------------
    // Apply inputs at a falling edge, hold them across one rising edge.
    task automatic cyc(input logic pv, input logic [7:0] px, input logic ordy);
        pix_valid = pv;
        pix_in    = px;
        out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_in    = 8'h00;
        out_ready = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_row(input string nm, input logic [7:0] base);
        for (int k = 0; k < 8; k++)
            chk(nm, 32'(xv[k]), 32'(xf(8'(base + k))));
    endtask

    initial begin
        // 1: reset state
        do_reset(2);
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_row",   32'(out_row),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        for (int k = 0; k < 8; k++) chk("rst_x", 32'(xv[k]), 32'd0);

        // 2: one row 0..7, valid the cycle after the 8th accept
        for (int i = 0; i < 8; i++) begin
            chk("t2_out_valid_low", 32'(out_valid), 32'd0);
            cyc(1'b1, 8'(i), 1'b1);
        end
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk_row("t2_x", 8'd0);
        chk("t2_x0_lit", 32'(x0), 32'(`ifdef DCT_LEVEL_SHIFT_EN 8'h80 `else 8'h00 `endif));
        cyc(1'b0, 8'h00, 1'b1);
        chk("t2_drained", 32'(out_valid), 32'd0);

        // 3: stall downstream, 16 pixels fill both banks, 17th is refused
        do_reset(2);
        for (int i = 0; i < 17; i++) begin
            if (i == 15) chk("t3_ready_15", 32'(pix_ready), 32'd1);
            if (i == 16) chk("t3_ready_16", 32'(pix_ready), 32'd0);
            cyc(1'b1, 8'(i), 1'b0);
        end
        chk("t3_still_blocked", 32'(pix_ready), 32'd0);
        chk_row("t3_row0_held", 8'd0);
        cyc(1'b1, 8'd16, 1'b1);              // first row handshake, pixel 16 refused
        chk("t3_ready_after_hs", 32'(pix_ready), 32'd1);
        chk("t3_valid_row1", 32'(out_valid), 32'd1);
        chk_row("t3_row1", 8'd8);
        chk("t3_out_row1", 32'(out_row), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t3_empty", 32'(out_valid), 32'd0);

        // 4: nine back-to-back rows, block row index wraps
        do_reset(2);
        for (int r = 0; r < 9; r++) begin
            for (int k = 0; k < 8; k++) cyc(1'b1, 8'(r * 8 + k), 1'b1);
            chk("t4_valid", 32'(out_valid), 32'd1);
            chk("t4_out_row", 32'(out_row), 32'(r % 8));
            chk("t4_out_last", 32'(out_last), 32'(r == 7));
            chk("t4_x0", 32'(x0), 32'(xf(8'(r * 8))));
        end
        cyc(1'b0, 8'h00, 1'b1);
        chk("t4_drained", 32'(out_valid), 32'd0);

        // 5: reset mid-row discards the partial row
        do_reset(2);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(100 + i), 1'b0);
        do_reset(1);
        chk("t5_no_row", 32'(out_valid), 32'd0);
        for (int i = 8; i < 16; i++) begin
            chk("t5_no_early_row", 32'(out_valid), 32'd0);
            cyc(1'b1, 8'(i), 1'b0);
        end
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk_row("t5_x", 8'd8);
        chk("t5_out_row", 32'(out_row), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t5_single_row", 32'(out_valid), 32'd0);

        // 6: bank B completes on the same edge bank A drains
        do_reset(2);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0);
        for (int i = 20; i < 27; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("t6_a_waiting", 32'(out_valid), 32'd1);
        cyc(1'b1, 8'd27, 1'b1);
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk_row("t6_bank_b", 8'd20);
        chk("t6_ready", 32'(pix_ready), 32'd1);
        chk("t6_out_row", 32'(out_row), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t6_drained", 32'(out_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
